// File: rtl/regfile_seq_if.sv
// Command/response channel between the datapath control (master) and the regfile sequencer (slave).
// A command transfers when cmd_valid and cmd_ready are both high at a rising clock edge.
interface regfile_seq_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;
    logic [DW-1:0] cmd_imm;
    logic          done;
    logic          err;
    logic [DW-1:0] rsp_data;
    logic          busy;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm,
        input  cmd_ready, done, err, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_imm,
        output cmd_ready, done, err, rsp_data, busy
    );
endinterface

// File: rtl/regfile_seq.sv
// Command sequencer for the 32x32 register file: expands LOAD/MOVE/SWAP/CLEAR commands
// into timed regfile reads (sampled at negedge by the regfile) and writes (taken at posedge).
module regfile_seq #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          reset,
    regfile_seq_if.slave  cmd,
    output logic          rf_en,
    output logic          rf_read,
    output logic          rf_write,
    output logic [AW-1:0] rf_selout,
    output logic [AW-1:0] rf_selin,
    output logic [DW-1:0] rf_inp,
    input  logic [DW-1:0] rf_out
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, CLR, DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_MOVE, OP_SWAP, OP_CLEAR} op_t;

    localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST   = AW'(NREG - 1);

    state_t        state;
    state_t        next_state;
    op_t           op_q;
    logic [AW-1:0] ra_q;
    logic [AW-1:0] rb_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] tmp_a;
    logic [DW-1:0] tmp_b;
    logic [AW-1:0] cnt;
    logic          err_q;
    logic [DW-1:0] rsp_q;
    logic          handshake;
    logic          cmd_bad;

    assign handshake = cmd.cmd_valid && (state == IDLE);

    // CLEAR uses no address, so it can never be rejected.
    always_comb begin
        cmd_bad = 1'b0;
        case (op_t'(cmd.cmd_op))
            OP_LOAD:          cmd_bad = ({1'b0, cmd.cmd_ra} >= NREG_W);
            OP_MOVE, OP_SWAP: cmd_bad = ({1'b0, cmd.cmd_ra} >= NREG_W) ||
                                        ({1'b0, cmd.cmd_rb} >= NREG_W);
            default:          cmd_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rf_en      = 1'b0;
        rf_read    = 1'b0;
        rf_write   = 1'b0;
        rf_selout  = '0;
        rf_selin   = '0;
        rf_inp     = '0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (cmd_bad) begin
                        next_state = DONE;
                    end else begin
                        case (op_t'(cmd.cmd_op))
                            OP_LOAD: next_state = WR_A;
                            OP_MOVE: next_state = RD_B;
                            OP_SWAP: next_state = RD_A;
                            default: next_state = CLR;
                        endcase
                    end
                end
            end
            RD_A: begin
                rf_en      = 1'b1;
                rf_read    = 1'b1;
                rf_selout  = ra_q;
                next_state = RD_B;
            end
            RD_B: begin
                rf_en      = 1'b1;
                rf_read    = 1'b1;
                rf_selout  = rb_q;
                next_state = WR_A;
            end
            WR_A: begin
                rf_en      = 1'b1;
                rf_write   = 1'b1;
                rf_selin   = ra_q;
                rf_inp     = (op_q == OP_LOAD) ? imm_q : tmp_b;
                next_state = (op_q == OP_SWAP) ? WR_B : DONE;
            end
            WR_B: begin
                rf_en      = 1'b1;
                rf_write   = 1'b1;
                rf_selin   = rb_q;
                rf_inp     = tmp_a;
                next_state = DONE;
            end
            CLR: begin
                rf_en      = 1'b1;
                rf_write   = 1'b1;
                rf_selin   = cnt;
                rf_inp     = '0;
                next_state = (cnt == LAST) ? DONE : CLR;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Response is loaded on the transition into DONE and held there until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_LOAD;
            ra_q  <= '0;
            rb_q  <= '0;
            imm_q <= '0;
            tmp_a <= '0;
            tmp_b <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
            rsp_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        op_q  <= op_t'(cmd.cmd_op);
                        ra_q  <= cmd.cmd_ra;
                        rb_q  <= cmd.cmd_rb;
                        imm_q <= cmd.cmd_imm;
                        cnt   <= '0;
                        err_q <= cmd_bad;
                        if (cmd_bad) begin
                            rsp_q <= '0;
                        end
                    end
                end
                RD_A: tmp_a <= rf_out;
                RD_B: tmp_b <= rf_out;
                WR_A: begin
                    if (op_q != OP_SWAP) begin
                        rsp_q <= (op_q == OP_LOAD) ? imm_q : tmp_b;
                    end
                end
                WR_B: rsp_q <= tmp_a;
                CLR: begin
                    if (cnt == LAST) begin
                        rsp_q <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                DONE:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.busy      = (state != IDLE);
    assign cmd.done      = (state == DONE);
    assign cmd.err       = err_q;
    assign cmd.rsp_data  = rsp_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: a 32-register instance driving a behavioural regfile, plus a
// 20-register instance for out-of-range addresses and back-to-back command traffic.
module tb_regfile_seq;
    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_seq_if #(.DW(DW), .AW(AW)) bus32 ();
    regfile_seq_if #(.DW(DW), .AW(AW)) bus20 ();

    logic          rf_en, rf_read, rf_write;
    logic [AW-1:0] rf_selout, rf_selin;
    logic [DW-1:0] rf_inp;
    logic [DW-1:0] rf_out = '0;

    logic          rf_en20, rf_read20, rf_write20;
    logic [AW-1:0] rf_selout20, rf_selin20;
    logic [DW-1:0] rf_inp20;
    logic [DW-1:0] rf_out20;
    assign rf_out20 = '0;

    regfile_seq #(.DW(DW), .AW(AW), .NREG(32)) dut (
        .clk(clk), .reset(reset), .cmd(bus32),
        .rf_en(rf_en), .rf_read(rf_read), .rf_write(rf_write),
        .rf_selout(rf_selout), .rf_selin(rf_selin), .rf_inp(rf_inp), .rf_out(rf_out)
    );

    regfile_seq #(.DW(DW), .AW(AW), .NREG(20)) dut20 (
        .clk(clk), .reset(reset), .cmd(bus20),
        .rf_en(rf_en20), .rf_read(rf_read20), .rf_write(rf_write20),
        .rf_selout(rf_selout20), .rf_selin(rf_selin20), .rf_inp(rf_inp20), .rf_out(rf_out20)
    );

    // Stimulus fields are shared; use20 picks which instance sees cmd_valid and is observed.
    logic          use20 = 1'b0;
    logic          tb_valid = 1'b0;
    logic [1:0]    tb_op = 2'b00;
    logic [AW-1:0] tb_ra = '0;
    logic [AW-1:0] tb_rb = '0;
    logic [DW-1:0] tb_imm = '0;

    assign bus32.cmd_valid = tb_valid & ~use20;
    assign bus32.cmd_op    = tb_op;
    assign bus32.cmd_ra    = tb_ra;
    assign bus32.cmd_rb    = tb_rb;
    assign bus32.cmd_imm   = tb_imm;
    assign bus20.cmd_valid = tb_valid & use20;
    assign bus20.cmd_op    = tb_op;
    assign bus20.cmd_ra    = tb_ra;
    assign bus20.cmd_rb    = tb_rb;
    assign bus20.cmd_imm   = tb_imm;

    wire          cur_ready = use20 ? bus20.cmd_ready : bus32.cmd_ready;
    wire          cur_done  = use20 ? bus20.done      : bus32.done;
    wire          cur_err   = use20 ? bus20.err       : bus32.err;
    wire [DW-1:0] cur_rsp   = use20 ? bus20.rsp_data  : bus32.rsp_data;
    wire          mon_en    = use20 ? rf_en20         : rf_en;
    wire          mon_read  = use20 ? rf_read20       : rf_read;
    wire          mon_write = use20 ? rf_write20      : rf_write;
    wire [AW-1:0] mon_selin = use20 ? rf_selin20      : rf_selin;
    wire [DW-1:0] mon_inp   = use20 ? rf_inp20        : rf_inp;

    // Behavioural regfile: write on posedge, read data updates on negedge.
    logic [DW-1:0] regs [32];
    always @(posedge clk) if (rf_en && rf_write) regs[rf_selin] <= rf_inp;
    always @(negedge clk) if (rf_en && rf_read) rf_out <= regs[rf_selout];

    int en_total = 0, wr_total = 0, rd_total = 0, conflict_total = 0;
    int hs_total = 0, done_total = 0, done_noerr_total = 0;
    logic [AW-1:0] wr_sel_q [$];
    logic [DW-1:0] wr_dat_q [$];

    always @(negedge clk) begin
        if (!reset) begin
            if (mon_en) en_total++;
            if (mon_en && mon_write) begin
                wr_total++;
                wr_sel_q.push_back(mon_selin);
                wr_dat_q.push_back(mon_inp);
            end
            if (mon_en && mon_read) rd_total++;
            if (mon_read && mon_write) conflict_total++;
            if (tb_valid && cur_ready) hs_total++;
            if (cur_done) begin
                done_total++;
                if (!cur_err) done_noerr_total++;
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one command and returns cycles from handshake edge to the cycle done is seen.
    task automatic apply_stimulus(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                  input logic [DW-1:0] imm, output int lat,
                                  output logic [DW-1:0] rsp, output logic err);
        int n;
        n = 0;
        while (!cur_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        lat = -1;
        rsp = '0;
        err = 1'b0;
        if (cur_ready) begin
            tb_op = op; tb_ra = ra; tb_rb = rb; tb_imm = imm;
            tb_valid = 1'b1;
            @(posedge clk); #1;
            tb_valid = 1'b0;
            n = 1;
            while (!cur_done && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (cur_done) lat = n;
            rsp = cur_rsp;
            err = cur_err;
        end
    endtask

    typedef struct {
        logic          use20;
        logic [1:0]    op;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp_rsp;
        logic          exp_err;
        int            exp_lat;
        int            exp_wr;
        int            exp_rd;
        logic          chk;
        logic [AW-1:0] chk_reg;
        logic [DW-1:0] exp_val;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    initial begin
        int lat, en0, wr0, rd0, qs, bad, n;
        logic [DW-1:0] rsp;
        logic err;

        vecs[0]  = '{1'b0, OP_LOAD,  5'd3,  5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b1, 5'd3,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, OP_LOAD,  5'd5,  5'd0, 32'h12345678, 32'h12345678, 1'b0, 2, 1, 0, 1'b1, 5'd5,  32'h12345678};
        vecs[2]  = '{1'b0, OP_MOVE,  5'd9,  5'd5, 32'h0,        32'h12345678, 1'b0, 3, 1, 1, 1'b1, 5'd9,  32'h12345678};
        vecs[3]  = '{1'b0, OP_LOAD,  5'd1,  5'd0, 32'hA,        32'hA,        1'b0, 2, 1, 0, 1'b1, 5'd5,  32'h12345678};
        vecs[4]  = '{1'b0, OP_LOAD,  5'd2,  5'd0, 32'hB,        32'hB,        1'b0, 2, 1, 0, 1'b1, 5'd2,  32'hB};
        vecs[5]  = '{1'b0, OP_SWAP,  5'd1,  5'd2, 32'h0,        32'hA,        1'b0, 5, 2, 2, 1'b1, 5'd1,  32'hB};
        vecs[6]  = '{1'b0, OP_LOAD,  5'd4,  5'd0, 32'h44444444, 32'h44444444, 1'b0, 2, 1, 0, 1'b1, 5'd4,  32'h44444444};
        vecs[7]  = '{1'b0, OP_SWAP,  5'd4,  5'd4, 32'h0,        32'h44444444, 1'b0, 5, 2, 2, 1'b1, 5'd4,  32'h44444444};
        vecs[8]  = '{1'b0, OP_LOAD,  5'd7,  5'd0, 32'h77,       32'h77,       1'b0, 2, 1, 0, 1'b1, 5'd7,  32'h77};
        vecs[9]  = '{1'b0, OP_MOVE,  5'd7,  5'd7, 32'h0,        32'h77,       1'b0, 3, 1, 1, 1'b1, 5'd7,  32'h77};
        vecs[10] = '{1'b0, OP_LOAD,  5'd0,  5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2, 1, 0, 1'b1, 5'd0,  32'hFFFFFFFF};
        vecs[11] = '{1'b0, OP_LOAD,  5'd31, 5'd0, 32'h80000001, 32'h80000001, 1'b0, 2, 1, 0, 1'b1, 5'd31, 32'h80000001};
        vecs[12] = '{1'b1, OP_LOAD,  5'd25, 5'd0, 32'h5,        32'h0,        1'b1, 1, 0, 0, 1'b0, 5'd0,  32'h0};
        vecs[13] = '{1'b1, OP_MOVE,  5'd3,  5'd22, 32'h0,       32'h0,        1'b1, 1, 0, 0, 1'b0, 5'd0,  32'h0};
        vecs[14] = '{1'b1, OP_SWAP,  5'd20, 5'd0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 5'd0,  32'h0};
        vecs[15] = '{1'b1, OP_LOAD,  5'd19, 5'd0, 32'h19,       32'h19,       1'b0, 2, 1, 0, 1'b0, 5'd0,  32'h0};
        vecs[16] = '{1'b1, OP_CLEAR, 5'd0,  5'd0, 32'h0,        32'h0,        1'b0, 21, 20, 0, 1'b0, 5'd0, 32'h0};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_ready", bus32.cmd_ready, 1);
        check_output("rst_busy", bus32.busy, 0);
        check_output("rst_done", bus32.done, 0);
        check_output("rst_err", bus32.err, 0);
        check_output("rst_rsp", bus32.rsp_data, 0);
        check_output("rst_rf_en", rf_en, 0);
        check_output("rst_rf_write", rf_write, 0);
        check_output("rst_rf_read", rf_read, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a SWAP: ra has been written, rb write is abandoned.
        apply_stimulus(OP_LOAD, 5'd10, 5'd0, 32'h1010, lat, rsp, err);
        apply_stimulus(OP_LOAD, 5'd11, 5'd0, 32'h1111, lat, rsp, err);
        n = 0;
        while (!cur_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tb_op = OP_SWAP; tb_ra = 5'd10; tb_rb = 5'd11;
        tb_valid = 1'b1;
        @(posedge clk); #1;
        tb_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_output("swap_wrb_write", rf_write, 1);
        check_output("swap_wrb_sel", rf_selin, 11);
        reset = 1'b1;
        #1;
        check_output("midrst_rf_write", rf_write, 0);
        check_output("midrst_ready", bus32.cmd_ready, 1);
        check_output("midrst_rf_en", rf_en, 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check_output("midrst_ra_written", regs[10], 32'h1111);
        check_output("midrst_rb_untouched", regs[11], 32'h1111);
        check_output("midrst_rsp", bus32.rsp_data, 0);

        for (int i = 0; i < NVEC; i++) begin
            use20 = vecs[i].use20;
            en0 = en_total; wr0 = wr_total; rd0 = rd_total;
            apply_stimulus(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].imm, lat, rsp, err);
            check_output($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check_output($sformatf("v%0d_rsp", i), rsp, vecs[i].exp_rsp);
            check_output($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            check_output($sformatf("v%0d_writes", i), wr_total - wr0, vecs[i].exp_wr);
            check_output($sformatf("v%0d_reads", i), rd_total - rd0, vecs[i].exp_rd);
            check_output($sformatf("v%0d_en", i), en_total - en0, vecs[i].exp_wr + vecs[i].exp_rd);
            if (vecs[i].chk) begin
                check_output($sformatf("v%0d_reg", i), regs[vecs[i].chk_reg], vecs[i].exp_val);
            end
        end
        check_output("swap_r2", regs[2], 32'hA);

        // Fill every register with its index, then CLEAR.
        use20 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(OP_LOAD, AW'(i), 5'd0, DW'(i), lat, rsp, err);
        end
        check_output("fill_r31", regs[31], 31);
        check_output("fill_r17", regs[17], 17);
        qs = wr_sel_q.size();
        apply_stimulus(OP_CLEAR, 5'd0, 5'd0, 32'h0, lat, rsp, err);
        check_output("clear_lat", lat, 33);
        check_output("clear_rsp", rsp, 0);
        check_output("clear_err", err, 0);
        check_output("clear_writes", wr_sel_q.size() - qs, 32);
        bad = 0;
        if (wr_sel_q.size() >= qs + 32) begin
            for (int k = 0; k < 32; k++) begin
                if (wr_sel_q[qs + k] != AW'(k) || wr_dat_q[qs + k] != '0) bad++;
            end
        end else begin
            bad = 32;
        end
        check_output("clear_order", bad, 0);
        bad = 0;
        for (int k = 0; k < 32; k++) if (regs[k] != '0) bad++;
        check_output("clear_all_zero", bad, 0);

        // cmd_valid held high: one rejected LOAD per completion, two cycles each.
        use20 = 1'b1;
        n = 0;
        while (!cur_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        en0 = hs_total; wr0 = done_total; rd0 = done_noerr_total; qs = en_total;
        tb_op = OP_LOAD; tb_ra = 5'd25; tb_rb = 5'd0; tb_imm = 32'hCAFE;
        tb_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("b2b_handshakes", hs_total - en0, 10);
        check_output("b2b_dones", done_total - wr0, 10);
        check_output("b2b_noerr_dones", done_noerr_total - rd0, 0);
        check_output("b2b_rf_en", en_total - qs, 0);

        check_output("rw_conflicts", conflict_total, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
